// File: rtl/phy_tx_pkg.sv
// rtl/phy_tx_pkg.sv - shared characters, FSM encoding and width helper for the lane transmitter
package phy_tx_pkg;

  localparam logic [7:0] COM_CHAR_DEF  = 8'hBC;
  localparam logic [7:0] IDLE_CHAR_DEF = 8'h7C;

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } tx_state_e;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/phy_tx_lanes_if.sv
// rtl/phy_tx_lanes_if.sv - lane word source / recirculation sink bundle
interface phy_tx_lanes_if #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8
) ();
  logic [NUM_LANES*DATA_W-1:0] data_in;
  logic [NUM_LANES-1:0]        valid_in;
  logic [NUM_LANES-1:0]        in_ready;
  logic [NUM_LANES*DATA_W-1:0] recirc_data;
  logic [NUM_LANES-1:0]        recirc_valid;

  modport master (
    output data_in, valid_in,
    input  in_ready, recirc_data, recirc_valid
  );

  modport slave (
    input  data_in, valid_in,
    output in_ready, recirc_data, recirc_valid
  );
endinterface

// File: rtl/phy_tx_serializer.sv
// rtl/phy_tx_serializer.sv - MSB-first word serializer; PHY_TX_PARITY_EN appends an even parity bit per slot
module phy_tx_serializer
  import phy_tx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_word,
  output logic              serial_out,
  output logic              slot_start,
  output logic              slot_end
);

`ifdef PHY_TX_PARITY_EN
  localparam int SLOT_LEN = DATA_W + 1;
`else
  localparam int SLOT_LEN = DATA_W;
`endif
  localparam int CNT_W = clog2_min1(SLOT_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLOT_LEN - 1);

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              serial_q, serial_d;
`ifdef PHY_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign slot_start = (bit_cnt_q == '0);
  assign slot_end   = (bit_cnt_q == LAST_BIT);
  assign serial_out = serial_q;

  // The MSB goes straight to the output register on the load edge, so the
  // shift register only needs to hold the bits still to come.
  always_comb begin
    bit_cnt_d = slot_end ? '0 : bit_cnt_q + 1'b1;
    shreg_d   = shreg_q << 1;
    serial_d  = shreg_q[DATA_W-1];
`ifdef PHY_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (load) begin
      shreg_d  = load_word << 1;
      serial_d = load_word[DATA_W-1];
`ifdef PHY_TX_PARITY_EN
      parity_d = ^load_word;
`endif
    end
`ifdef PHY_TX_PARITY_EN
    else if (bit_cnt_q == CNT_W'(DATA_W)) begin
      serial_d = parity_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      serial_q  <= 1'b0;
`ifdef PHY_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      serial_q  <= serial_d;
`ifdef PHY_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: rtl/phy_tx_lanes.sv
// rtl/phy_tx_lanes.sv - round-robin lane merger with SYNC/ACTIVE training FSM; PHY_TX_PARITY_EN adds a parity bit per slot
module phy_tx_lanes
  import phy_tx_pkg::*;
#(
  parameter int                NUM_LANES   = 4,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] COM_CHAR    = DATA_W'(COM_CHAR_DEF),
  parameter logic [DATA_W-1:0] IDLE_CHAR   = DATA_W'(IDLE_CHAR_DEF),
  parameter int                SYNC_FRAMES = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             active,
  phy_tx_lanes_if.slave    lanes,
  output logic             serial_out,
  output logic             link_up
);

  localparam int LANE_W = clog2_min1(NUM_LANES);
  localparam int FC_W   = clog2_min1(SYNC_FRAMES + 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
  localparam logic [FC_W-1:0]   FC_MAX    = FC_W'(SYNC_FRAMES);

  logic                        sync1_q, sync2_q;
  logic [LANE_W-1:0]           lane_cnt_q, lane_cnt_d;
  logic [FC_W-1:0]             frame_cnt_q, frame_cnt_d, frame_cnt_inc;
  tx_state_e                   state_q, state_d;
  logic                        link_up_q, link_up_d;
  logic [NUM_LANES-1:0]        in_ready_q, in_ready_d;
  logic [NUM_LANES-1:0]        recirc_valid_q, recirc_valid_d;
  logic [NUM_LANES*DATA_W-1:0] recirc_data_q, recirc_data_d;

  logic              slot_start, slot_end, frame_end;
  logic [DATA_W-1:0] lane_word, load_word;
  logic              lane_valid;

  assign lane_word  = lanes.data_in[int'(lane_cnt_q)*DATA_W +: DATA_W];
  assign lane_valid = lanes.valid_in[lane_cnt_q];
  assign frame_end  = slot_end && (lane_cnt_q == LAST_LANE);

  always_comb begin
    load_word      = COM_CHAR;
    in_ready_d     = '0;
    recirc_valid_d = '0;
    recirc_data_d  = recirc_data_q;
    if (slot_start) begin
      if (state_q == ST_ACTIVE) begin
        load_word = lane_valid ? lane_word : IDLE_CHAR;
        if (lane_valid) in_ready_d[lane_cnt_q] = 1'b1;
      end else if (lane_valid) begin
        // Untrained link: the word is handed back to the source instead of sent.
        in_ready_d[lane_cnt_q]     = 1'b1;
        recirc_valid_d[lane_cnt_q] = 1'b1;
        recirc_data_d[int'(lane_cnt_q)*DATA_W +: DATA_W] = lane_word;
      end
    end
  end

  always_comb begin
    lane_cnt_d    = lane_cnt_q;
    frame_cnt_inc = (frame_cnt_q >= FC_MAX) ? FC_MAX : frame_cnt_q + 1'b1;
    frame_cnt_d   = frame_cnt_q;
    state_d       = state_q;
    if (slot_end) lane_cnt_d = (lane_cnt_q == LAST_LANE) ? '0 : lane_cnt_q + 1'b1;
    // State only moves on a frame boundary so a frame is never split between modes.
    if (frame_end) begin
      case (state_q)
        ST_SYNC: begin
          frame_cnt_d = frame_cnt_inc;
          if (sync2_q && (frame_cnt_inc >= FC_MAX)) state_d = ST_ACTIVE;
        end
        default: begin
          if (!sync2_q) begin
            state_d     = ST_SYNC;
            frame_cnt_d = '0;
          end
        end
      endcase
    end
    link_up_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      lane_cnt_q     <= '0;
      frame_cnt_q    <= '0;
      state_q        <= ST_SYNC;
      link_up_q      <= 1'b0;
      in_ready_q     <= '0;
      recirc_valid_q <= '0;
      recirc_data_q  <= '0;
    end else begin
      sync1_q        <= active;
      sync2_q        <= sync1_q;
      lane_cnt_q     <= lane_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      state_q        <= state_d;
      link_up_q      <= link_up_d;
      in_ready_q     <= in_ready_d;
      recirc_valid_q <= recirc_valid_d;
      recirc_data_q  <= recirc_data_d;
    end
  end

  phy_tx_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk        (clk_32f),
    .rst_n      (reset),
    .load       (slot_start),
    .load_word  (load_word),
    .serial_out (serial_out),
    .slot_start (slot_start),
    .slot_end   (slot_end)
  );

  assign lanes.in_ready     = in_ready_q;
  assign lanes.recirc_valid = recirc_valid_q;
  assign lanes.recirc_data  = recirc_data_q;
  assign link_up            = link_up_q;

endmodule

// File: doc/phy_tx_lanes.md
Name: phy_tx_lanes

Overview:
Parametrised successor to the fixed 4-lane, 8-bit physical transmitter. It merges NUM_LANES parallel lanes of DATA_W bits into one serial bitstream on a single bit-rate clock, servicing the lanes round-robin. A sync/active state machine governs the output:
- Not active: the link is trained with COM characters, and lane data is routed to the recirculation outputs.
- Active: lane data is serialised; IDLE fills any lane slot without valid data.

Parameters:
NUM_LANES, 4, number of input lanes (>=1; need not be a power of two).
DATA_W, 8, bits per lane word.
COM_CHAR, 8'hBC, training character sent in SYNC; width DATA_W.
IDLE_CHAR, 8'h7C, filler sent in ACTIVE when a lane is not valid; width DATA_W.
SYNC_FRAMES, 4, minimum number of complete COM frames sent before ACTIVE may be entered.

Ports:
clk_32f  in  1  bit-rate clock; the single clock of the block.
reset  in  1  asynchronous, active-low reset.
active  in  1  link-up indication from the receiver; asynchronous to clk_32f.
data_in  in  NUM_LANES*DATA_W  lane words; lane l occupies bits [l*DATA_W +: DATA_W].
valid_in  in  NUM_LANES  per-lane valid.
in_ready  out  NUM_LANES  one-cycle pulse when lane l's word is consumed.
serial_out  out  1  serial bitstream, MSB first.
recirc_data  out  NUM_LANES*DATA_W  recirculated lane words.
recirc_valid  out  NUM_LANES  per-lane recirculation valid; one-cycle pulse.
link_up  out  1  high while the FSM is in ACTIVE.

Behaviour:
- Reset (reset=0, asynchronous): serial_out=0, in_ready=0, recirc_data=0, recirc_valid=0, link_up=0. Bit counter, lane counter and frame counter = 0. FSM = SYNC. Synchroniser flops = 0.
- active passes through a 2-flop synchroniser (active_s). Latency from active to active_s is 2 edges.
- Framing:
  - A word slot is DATA_W cycles (bit_cnt 0..DATA_W-1).
  - A frame is NUM_LANES slots (lane_cnt 0..NUM_LANES-1).
  - Both counters wrap to 0.
- Slot start (bit_cnt==0) for lane l = lane_cnt:
  - SYNC: shift register loads COM_CHAR. If valid_in[l]=1, then recirc_data[l] is set to data_in[l] and recirc_valid[l] and in_ready[l] pulse for that one cycle.
  - ACTIVE: if valid_in[l]=1, the shift register loads data_in[l] and in_ready[l] pulses. Otherwise it loads IDLE_CHAR and in_ready[l] stays 0. recirc_valid stays 0.
- Other cycles: the shift register shifts left by one.
- serial_out is the registered MSB of the shift register. The MSB of a word sampled at edge E is on serial_out from E until E+1. The remaining bits follow one per cycle.
- The first edge after reset release loads lane 0.
- Frame boundary is the edge where lane_cnt==NUM_LANES-1 and bit_cnt==DATA_W-1. FSM transitions take effect only at this boundary, so the next frame starts in the new state:
  - In SYNC, frame_cnt increments at each boundary and saturates at SYNC_FRAMES.
  - SYNC->ACTIVE when active_s=1 and frame_cnt>=SYNC_FRAMES.
  - ACTIVE->SYNC when active_s=0. frame_cnt clears to 0 on this transition.
- active changing mid-frame: the current frame completes unchanged. A deassert/reassert shorter than one frame, if sampled low at a boundary, still forces a full SYNC_FRAMES retraining.
- link_up is registered and changes on the same edge as the FSM state.
- valid_in held high in ACTIVE: the lane is consumed once per frame. The source must present its next word by that lane's next slot.
- NUM_LANES=1: every slot is lane 0, and the frame length is DATA_W cycles.
- Reset asserted mid-word aborts the word immediately. Outputs go to their reset values.

Optional Feature:
PHY_TX_PARITY_EN
- Defined: each slot is DATA_W+1 cycles. The bit after the LSB is even parity over the word actually sent (COM, IDLE or data). Frame length is NUM_LANES*(DATA_W+1).
- Undefined: no parity bit; slots are DATA_W cycles. The bit counter width is sized for whichever slot length applies.

Decomposition:
- Package phy_tx_pkg holds:
  - default COM/IDLE characters
  - FSM state encoding (SYNC, ACTIVE)
  - a clog2 helper for counter widths
- One natural sub-module, phy_tx_serializer:
  - owns the shift register, bit counter and optional parity bit
  - accepts a load pulse plus a word, and emits serial_out and slot_end
- Lane selection, the FSM, the synchroniser and recirculation stay in the top module.

Test Plan:
- Reset held 10 cycles, then released with active=0 -> serial_out shows 0xBC repeated, i.e. 10111100 x4 per frame (32 bits). link_up=0.
- active=1 from cycle 0, defaults -> link_up rises at the end of frame 4 (bit 128). Frame 5 carries lane words 0xA5,0x3C,0xFF,0x00 MSB first. in_ready pulses at cycles 128,136,144,152.
- ACTIVE with valid_in=4'b0101 -> slots 1 and 3 carry 0x7C. in_ready[1] and in_ready[3] never pulse.
- SYNC with valid_in=4'b1111 and data 0x11,0x22,0x33,0x44 -> recirc_data per lane equals its data_in, with a one-cycle recirc_valid at each lane's slot start. serial_out stays 0xBC.
- active drops at bit 5 of lane 2 in ACTIVE -> lanes 2 and 3 complete with data. The next frame is COM, and 4 COM frames precede re-entry to ACTIVE.
- PHY_TX_PARITY_EN defined, DATA_W=8 -> 9-bit slots. COM 0xBC is followed by parity 1; data 0x03 is followed by parity 0.
